// File: rtl/isa_pkg.sv
// Opcode constants and sequencer state encoding shared by the decode stage.
package isa_pkg;
    localparam int OPW = 5;

    localparam logic [OPW-1:0] OP_NOP   = 5'b00000;
    localparam logic [OPW-1:0] OP_CALL  = 5'b11000;
    localparam logic [OPW-1:0] OP_CALL2 = 5'b11001;
    localparam logic [OPW-1:0] OP_RET   = 5'b11010;
    localparam logic [OPW-1:0] OP_RET2  = 5'b11011;
    localparam logic [OPW-1:0] OP_RTI   = 5'b11100;
    localparam logic [OPW-1:0] OP_RTI2  = 5'b11101;
    localparam logic [OPW-1:0] OP_INT1  = 5'b11110;
    localparam logic [OPW-1:0] OP_INT2  = 5'b11111;

    typedef enum logic [2:0] {
        IDLE,
        CALL2,
        RET2,
        RTI2,
        INT1,
        INT2,
        FLUSH
    } seq_state_t;
endpackage

// File: rtl/opcode_sequencer.sv
// Decode-stage sequencer: expands CALL/RET/RTI and interrupts into two-part
// opcodes, inserts post-return flush bubbles and load-use stall bubbles.
module opcode_sequencer
    import isa_pkg::*;
#(
    parameter int RET_BUBBLES = 2,
    parameter int OPW         = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] instOpCode,
    input  logic           instValid,
    input  logic           loadUseStall,
    input  logic           intReq,
    output logic [OPW-1:0] opCodeOut,
    output logic           makeMeBubble,
    output logic           pcHold,
    output logic           intAck
);
    seq_state_t state, stateNext;
    logic [1:0] bubbleCnt, bubbleCntNext;
    logic       intPending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bubbleCnt  <= '0;
            intPending <= 1'b0;
        end else begin
            state      <= stateNext;
            bubbleCnt  <= bubbleCntNext;
            // a request arriving on the ack cycle must not be lost
            intPending <= intReq | (intPending & ~intAck);
        end
    end

    always_comb begin
        stateNext     = state;
        bubbleCntNext = bubbleCnt;
        opCodeOut     = OPW'(OP_NOP);
        makeMeBubble  = 1'b0;
        pcHold        = 1'b0;
        intAck        = 1'b0;

        if (rst) begin
            makeMeBubble = 1'b1;
            pcHold       = 1'b1;
        end else if (loadUseStall) begin
            makeMeBubble = 1'b1;
            pcHold       = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (intPending) begin
                        opCodeOut = OPW'(OP_INT1);
                        pcHold    = 1'b1;
                        stateNext = INT1;
                    end else if (instValid) begin
                        unique case (instOpCode)
                            OPW'(OP_CALL): begin
                                opCodeOut = instOpCode;
                                pcHold    = 1'b1;
                                stateNext = CALL2;
                            end
                            OPW'(OP_RET): begin
                                opCodeOut = instOpCode;
                                pcHold    = 1'b1;
                                stateNext = RET2;
                            end
                            OPW'(OP_RTI): begin
                                opCodeOut = instOpCode;
                                pcHold    = 1'b1;
                                stateNext = RTI2;
                            end
                            // part-two codes are internal only; drop them
                            OPW'(OP_CALL2), OPW'(OP_RET2), OPW'(OP_RTI2),
                            OPW'(OP_INT1), OPW'(OP_INT2): opCodeOut = OPW'(OP_NOP);
                            default: opCodeOut = instOpCode;
                        endcase
                    end
                end
                INT1: begin
                    opCodeOut = OPW'(OP_INT2);
                    pcHold    = 1'b1;
                    stateNext = INT2;
                end
                INT2: begin
                    makeMeBubble = 1'b1;
                    intAck       = 1'b1;
                    stateNext    = IDLE;
                end
                CALL2: begin
                    opCodeOut = OPW'(OP_CALL2);
                    stateNext = IDLE;
                end
                RET2, RTI2: begin
                    opCodeOut     = (state == RET2) ? OPW'(OP_RET2) : OPW'(OP_RTI2);
                    bubbleCntNext = 2'(RET_BUBBLES);
                    if (RET_BUBBLES == 0) begin
                        stateNext = IDLE;
                    end else begin
                        pcHold    = 1'b1;
                        stateNext = FLUSH;
                    end
                end
                FLUSH: begin
                    makeMeBubble  = 1'b1;
                    bubbleCntNext = bubbleCnt - 2'd1;
                    if (bubbleCnt == 2'd1) begin
                        stateNext = IDLE;
                    end else begin
                        pcHold = 1'b1;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end
endmodule
